// File: rtl/axis_frame_tx_pkg.sv
// Shared types and default sizing for the AXI-Stream frame transmitter.
package axis_frame_tx_pkg;

  localparam int DefDataWidth = 32;
  localparam int DefDepth     = 16;
  localparam int DefLenWidth  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE_S = 2'd2
  } txState_e;

endpackage

// File: rtl/axis_tx_fifo.sv
// First-word-fall-through synchronous FIFO feeding the stream output.
// The head word is visible on headData_o whenever the FIFO is non-empty.
module axis_tx_fifo
  import axis_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DefDataWidth,
  parameter int DEPTH      = DefDepth
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   pushData_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DATA_WIDTH-1:0]   headData_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CountOne = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);
  localparam logic [AW:0]   CountMax = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q;
  logic [AW-1:0]         rdPtr_q;
  logic [AW:0]           count_q;
  logic                  doPush;
  logic                  doPop;

  assign full_o     = (count_q == CountMax);
  assign empty_o    = (count_q == '0);
  assign doPush     = push_i && !full_o;
  assign doPop      = pop_i && !empty_o;
  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge ACLK) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PtrOne;
      if (doPop)  rdPtr_q <= rdPtr_q + PtrOne;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: words are queued through the load port and
// sent as a frame of FRAME_LEN beats after START, with TLAST on the final beat.
// Optional macro AXIS_TX_UNDERRUN_CNT_EN adds a saturating UNDERRUN_CNT output
// counting SEND cycles spent waiting on an empty FIFO.
module axis_frame_tx
  import axis_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DefDataWidth,
  parameter int DEPTH      = DefDepth,
  parameter int LEN_WIDTH  = DefLenWidth
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    LOAD_VALID,
  input  logic [DATA_WIDTH-1:0]   LOAD_DATA,
  output logic                    LOAD_READY,
  input  logic                    START,
  input  logic [LEN_WIDTH-1:0]    FRAME_LEN,
  output logic                    M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT
`ifdef AXIS_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             UNDERRUN_CNT
`endif
);

  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  txState_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beatCnt_q, beatCnt_d;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [DATA_WIDTH-1:0] fifoHead;
  logic                  txValid;
  logic                  txLast;
  logic                  handshake;
  logic                  startAccept;

  assign LOAD_READY    = !fifoFull;
  assign handshake     = txValid && M_AXIS_TREADY;
  assign M_AXIS_TVALID = txValid;
  assign M_AXIS_TLAST  = txLast;
  assign M_AXIS_TDATA  = txValid ? fifoHead : '0;
  assign BUSY          = (state_q != IDLE);

  axis_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) uFifo (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .push_i     (LOAD_VALID && LOAD_READY),
    .pushData_i (LOAD_DATA),
    .pop_i      (handshake),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .headData_o (fifoHead),
    .count_o    (FIFO_COUNT)
  );

  // Frame sequencing: state, latched length and beat counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // Next-state and stream outputs; zero-length starts are dropped in IDLE.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beatCnt_d   = beatCnt_q;
    txValid     = 1'b0;
    txLast      = 1'b0;
    DONE        = 1'b0;
    startAccept = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && (FRAME_LEN != '0)) begin
          len_d       = FRAME_LEN;
          beatCnt_d   = '0;
          state_d     = SEND;
          startAccept = 1'b1;
        end
      end
      SEND: begin
        txValid = !fifoEmpty;
        txLast  = txValid && (beatCnt_q == (len_q - LenOne));
        if (handshake) begin
          beatCnt_d = beatCnt_q + LenOne;
          if (txLast) begin
            state_d = DONE_S;
          end
        end
      end
      DONE_S: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXIS_TX_UNDERRUN_CNT_EN
  logic [15:0] underrunCnt_q;

  assign UNDERRUN_CNT = underrunCnt_q;

  // Saturating count of starved SEND cycles, restarted by each accepted frame.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      underrunCnt_q <= '0;
    end else if (startAccept) begin
      underrunCnt_q <= '0;
    end else if ((state_q == SEND) && fifoEmpty && (underrunCnt_q != 16'hFFFF)) begin
      underrunCnt_q <= underrunCnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/axis_frame_tx.md
Name: axis_frame_tx

Overview:
- AXI-Stream frame transmitter. It is the master-side source that feeds the slave stream port of the coprocessor IP (S_AXIS_TDATA/TVALID/TLAST/TREADY).
- Software or a controller pushes words into an internal FIFO through a valid/ready load port, then issues START with a frame length.
- The block emits exactly that many beats on M_AXIS and marks the final beat with TLAST, honouring TREADY backpressure.

Parameters:
- DATA_WIDTH, 32, width of load and stream data.
- DEPTH, 16, FIFO depth in words; must be a power of 2, >= 2.
- LEN_WIDTH, 16, width of FRAME_LEN and the internal beat counter.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- LOAD_VALID  in  1  load word valid.
- LOAD_DATA  in  DATA_WIDTH  word to enqueue.
- LOAD_READY  out  1  FIFO not full.
- START  in  1  single-cycle frame start request.
- FRAME_LEN  in  LEN_WIDTH  number of beats; sampled when START is accepted.
- M_AXIS_TVALID  out  1  stream beat valid.
- M_AXIS_TDATA  out  DATA_WIDTH  stream data.
- M_AXIS_TLAST  out  1  final beat of frame.
- M_AXIS_TREADY  in  1  downstream ready.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse after the last beat handshakes.
- FIFO_COUNT  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
  - BUSY=0, DONE=0, FIFO_COUNT=0, LOAD_READY=1 after release.
  - FIFO pointers cleared and state=IDLE.
  - Reset mid-frame abandons the frame and flushes the FIFO; no DONE is issued.
- Load port:
  - A push occurs when LOAD_VALID && LOAD_READY.
  - LOAD_READY = (FIFO_COUNT != DEPTH), combinational from registered count.
  - When full, a same-cycle pop does not enable a push that cycle.
  - Push and pop in the same cycle when non-full leave the count unchanged.
- FSM states:
  - IDLE:
    - START with FRAME_LEN != 0 latches the length, clears the beat counter and goes to SEND.
    - START with FRAME_LEN == 0 is ignored: no beats, no DONE.
  - SEND:
    - M_AXIS_TVALID = (FIFO_COUNT != 0).
    - M_AXIS_TDATA = FIFO head (first-word-fall-through).
    - M_AXIS_TLAST = TVALID && (beat_cnt == len-1).
    - On a handshake (TVALID && TREADY): pop, beat_cnt++.
    - On the handshake of the last beat, go to DONE_S.
  - DONE_S: DONE=1 for one cycle, then IDLE.
- BUSY = state != IDLE.
- START while BUSY is ignored.
- Latency: START at edge N gives TVALID at N+1 if the FIFO is non-empty.
- Throughput: one beat per cycle while TREADY=1 and the FIFO is non-empty.
- Backpressure: while TVALID && !TREADY, TDATA and TLAST are held stable and TVALID is never withdrawn.
- Underrun (FIFO empty mid-frame): TVALID=0; the frame resumes when data arrives. This is not an error.
- FRAME_LEN greater than DEPTH is legal; the load port refills the FIFO while the frame streams.
- Words left in the FIFO after a frame stay queued for the next frame.
- beat_cnt is LEN_WIDTH bits and never wraps, because len <= 2^LEN_WIDTH-1.

Optional Feature:
- Macro: AXIS_TX_UNDERRUN_CNT_EN.
- Defined:
  - Adds output UNDERRUN_CNT [15:0].
  - Increments in each SEND cycle with FIFO empty and saturates at 16'hFFFF.
  - Cleared by reset and on each accepted START.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package axis_frame_tx_pkg:
  - State enum {IDLE, SEND, DONE_S}, 2-bit.
  - Default DATA_WIDTH/DEPTH/LEN_WIDTH constants.
- Sub-module axis_tx_fifo:
  - Parameterised FWFT synchronous FIFO (DEPTH, DATA_WIDTH).
  - Same ACLK/ARESETN.
  - Push/pop/full/empty/count ports.
- The top level holds the FSM, beat counter and optional underrun counter.

Test Plan:
- Basic frame:
  - Stimulus: load 32'h81000, 32'h46000; START with FRAME_LEN=2; TREADY=1.
  - Response: two beats on consecutive cycles; TLAST only on 32'h46000; DONE pulses one cycle later; FIFO_COUNT=0.
- Backpressure:
  - Stimulus: load 4 words 1..4; len=4; TREADY toggled 1,0,0,1,...
  - Response: TDATA/TLAST held during stalls; beats 1,2,3,4 in order; exactly one TLAST; DONE once.
- Underrun:
  - Stimulus: load 1 word; START len=3; add the 2 remaining words 5 cycles later.
  - Response: TVALID low while empty; no TLAST until beat 3; with AXIS_TX_UNDERRUN_CNT_EN, UNDERRUN_CNT=5.
- Full and len boundaries:
  - Stimulus 1: push 17 words with DEPTH=16.
    - Response: LOAD_READY=0 at count 16; 17th accepted only after a pop.
  - Stimulus 2: START len=0.
    - Response: no TVALID, no DONE.
  - Stimulus 3: START while BUSY.
    - Response: ignored.
- Reset mid-frame:
  - Stimulus: assert ARESETN=0 after beat 2 of 4.
  - Response: TVALID, BUSY and FIFO_COUNT drop to 0 immediately (asynchronously); no DONE; a fresh frame afterwards transmits correctly.
